reg_file_scoreboard: RTL and testbench
======================================

Name: reg_file_scoreboard

Overview:
- Parametrised successor to the single-cycle CPU register file.
- Provides NUM_READ combinational read ports, one synchronous write port, x0 hardwired to zero, and a continuous a0 tap for the testbench/display.
- Adds a per-register busy scoreboard: a decode-stage issue port marks a destination pending, and writeback clears it.
- Generates a stall request when any read port addresses a pending register; it sits between decode and execute in the pipelined core.

Parameters:
- ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32, register data width.
- NUM_READ, 2, number of read ports (1..4).
- A0_INDEX, 10, register index driven on a0.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- AD_R  input  NUM_READ*ADDRESS_WIDTH  read addresses; port k at bits [k*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- RD  output  NUM_READ*DATA_WIDTH  read data; port k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- RBUSY  output  NUM_READ  per-port pending flag
- STALL  output  1  OR of RBUSY over ports whose RVLD bit is set
- RVLD  input  NUM_READ  port k is in use this cycle; qualifies STALL only
- AD3  input  ADDRESS_WIDTH  write address
- WE3  input  1  write enable
- WD3  input  DATA_WIDTH  write data
- ISSUE  input  1  mark ISSUE_AD busy
- ISSUE_AD  input  ADDRESS_WIDTH  destination being issued
- a0  output  DATA_WIDTH  contents of register A0_INDEX (registered state)

Behaviour:
- **Reset:** rst_n low asynchronously clears all registers to 0 and all busy bits to 0. While rst_n is low: RD=0, RBUSY=0, STALL=0, a0=0. Release is synchronous to the next clk edge.
- **Write:** on posedge clk with WE3=1 and AD3!=0, reg[AD3]<=WD3. Writes to x0 are discarded.
- **Read:** combinational. RD[k] = 0 if AD_R[k]==0, otherwise reg[AD_R[k]] (see the optional bypass). Latency is 0 cycles.
- **a0:** always equals the stored reg[A0_INDEX]. It is never bypassed and updates the cycle after the write.
- **Scoreboard:** busy[ ] has 2**ADDRESS_WIDTH bits and busy[0] is constant 0. On posedge clk:
  - WE3=1 clears busy[AD3].
  - ISSUE=1 sets busy[ISSUE_AD].
  - If both target the same nonzero index, set wins: the new producer supersedes the old one.
  - ISSUE to x0 has no effect.
- **RBUSY[k]:** equals busy[AD_R[k]] and is combinational. If WE3=1 and AD3==AD_R[k] in the same cycle, RBUSY[k] is forced to 0 (the value is arriving now), except when ISSUE targets the same index this cycle; the current busy bit still governs in that case.
- **STALL:** |(RBUSY & RVLD).
- **Overflow:** none; issuing an already busy register leaves it busy. A write to a non-busy register is legal and leaves it non-busy.
- **Reset mid-operation:** all pending marks are lost. The core flushes on reset, so no recovery is required.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- **Defined:** write-to-read forwarding. If WE3=1, AD3!=0 and AD3==AD_R[k], then RD[k]=WD3 in the same cycle, and the RBUSY[k] same-cycle clearing described above applies.
- **Undefined:**
  - RD[k] returns the stored value, which is the old value in the write cycle.
  - RBUSY[k] is not cleared early; it stays at busy[AD_R[k]] until the cycle after the write.
  - Consumers therefore see one extra stall cycle.

Test Plan:
- Reset then read: rst_n=0 mid-run after writing reg5=0x1234 -> RD=0, RBUSY=0, STALL=0, a0=0. After release, reading AD_R[0]=5 returns 0.
- x0 protection: WE3=1, AD3=0, WD3=0xDEADBEEF; ISSUE=1, ISSUE_AD=0 -> reading x0 gives RD=0 and RBUSY=0.
- Basic write/read and a0: write reg10=0xCAFE0001 -> the next cycle a0=0xCAFE0001. Reading AD_R[1]=10 returns 0xCAFE0001.
- Scoreboard stall: ISSUE reg7; the next cycle AD_R[0]=7, RVLD=01 -> STALL=1. In the writeback cycle (WE3, AD3=7, WD3=0x55), with BYPASS_EN: STALL=0 and RD[0]=0x55. Without BYPASS_EN: STALL=1 that cycle, then 0 with RD[0]=0x55.
- Set-wins collision: busy[3]=1; same cycle WE3 to 3 and ISSUE_AD=3 -> busy[3] stays 1 and RBUSY stays 1 the following cycle.
- Unused port: ISSUE reg4, AD_R[1]=4 with RVLD[1]=0 -> RBUSY[1]=1, STALL=0.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_scoreboard
// Description : Multi-read / single-write register file with x0 tied to zero,
//               an a0 tap and a per-register busy scoreboard with stall output.
//               Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_scoreboard #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2,
  parameter int A0_INDEX      = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] AD_R,
  output logic [NUM_READ*DATA_WIDTH-1:0]    RD,
  output logic [NUM_READ-1:0]               RBUSY,
  output logic                              STALL,
  input  logic [NUM_READ-1:0]               RVLD,
  input  logic [ADDRESS_WIDTH-1:0]          AD3,
  input  logic                              WE3,
  input  logic [DATA_WIDTH-1:0]             WD3,
  input  logic                              ISSUE,
  input  logic [ADDRESS_WIDTH-1:0]          ISSUE_AD,
  output logic [DATA_WIDTH-1:0]             a0
);

  localparam int c_DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
  logic [c_DEPTH-1:0]    r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (WE3 && (AD3 != '0)) begin
      r_regs[AD3] <= WD3;
    end
  end

  // Entry 0 is never written after reset, so busy[0] stays 0.
  // Issue beats writeback: the newly issued producer supersedes the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i < c_DEPTH; i++) begin
        if (ISSUE && (ISSUE_AD == ADDRESS_WIDTH'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (WE3 && (AD3 == ADDRESS_WIDTH'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign a0 = r_regs[A0_INDEX];

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDRESS_WIDTH-1:0] w_ad;
    assign w_ad = AD_R[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
`ifdef REGFILE_BYPASS_EN
    logic w_wr_hit;
    logic w_issue_hit;
    // Forwarding is gated by rst_n so outputs stay zero throughout reset.
    assign w_wr_hit    = rst_n && WE3 && (AD3 == w_ad) && (w_ad != '0);
    assign w_issue_hit = ISSUE && (ISSUE_AD == w_ad);
    assign RD[k*DATA_WIDTH +: DATA_WIDTH] = w_wr_hit ? WD3 :
                                            ((w_ad == '0) ? '0 : r_regs[w_ad]);
    assign RBUSY[k] = r_busy[w_ad] & ~(w_wr_hit & ~w_issue_hit);
`else
    assign RD[k*DATA_WIDTH +: DATA_WIDTH] = (w_ad == '0) ? '0 : r_regs[w_ad];
    assign RBUSY[k] = r_busy[w_ad];
`endif
  end

  assign STALL = |(RBUSY & RVLD);

endmodule
`default_nettype wire

// File: tb/tb_reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_scoreboard
// Description : Self-checking bench for reg_file_scoreboard: directed scenarios
//               plus randomized traffic against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_scoreboard;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int NR  = 2;
  localparam int A0I = 10;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR*AW-1:0] AD_R;
  logic [NR*DW-1:0] RD;
  logic [NR-1:0]  RBUSY;
  logic           STALL;
  logic [NR-1:0]  RVLD;
  logic [AW-1:0]  AD3;
  logic           WE3;
  logic [DW-1:0]  WD3;
  logic           ISSUE;
  logic [AW-1:0]  ISSUE_AD;
  logic [DW-1:0]  a0;

  reg_file_scoreboard #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .A0_INDEX(A0I)
  ) dut (
    .clk(clk), .rst_n(rst_n), .AD_R(AD_R), .RD(RD), .RBUSY(RBUSY),
    .STALL(STALL), .RVLD(RVLD), .AD3(AD3), .WE3(WE3), .WD3(WD3),
    .ISSUE(ISSUE), .ISSUE_AD(ISSUE_AD), .a0(a0)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] m_rf   [32];
  bit            m_busy [32];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_clock();
    if (WE3 && AD3 != 0) m_rf[AD3] = WD3;
    if (WE3) m_busy[AD3] = 1'b0;
    if (ISSUE && ISSUE_AD != 0) m_busy[ISSUE_AD] = 1'b1;
  endtask

  task automatic check_outputs();
    logic [NR-1:0] exp_rb;
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] ad;
      logic [DW-1:0] exp_rd;
      bit fwd;
      ad  = AD_R[k*AW +: AW];
      fwd = BYP && rst_n && WE3 && (AD3 == ad) && (ad != 0);
      if (!rst_n || ad == 0) exp_rd = '0;
      else if (fwd)          exp_rd = WD3;
      else                   exp_rd = m_rf[ad];
      exp_rb[k] = rst_n && m_busy[ad] && !(fwd && !(ISSUE && ISSUE_AD == ad));
      check_val($sformatf("RD%0d[x%0d]", k, ad), RD[k*DW +: DW], exp_rd);
    end
    check_val("RBUSY", RBUSY, exp_rb);
    check_val("STALL", STALL, |(exp_rb & RVLD));
    check_val("a0", a0, rst_n ? m_rf[A0I] : '0);
  endtask

  // Inputs are set 1ns after a rising edge; outputs are checked mid-cycle.
  task automatic tick();
    #3;
    check_outputs();
    @(posedge clk);
    if (rst_n) model_clock();
    #1;
  endtask

  task automatic idle();
    WE3 = 1'b0; AD3 = '0; WD3 = '0; ISSUE = 1'b0; ISSUE_AD = '0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] ad);
    AD_R[k*AW +: AW] = ad;
  endtask

  function automatic logic [AW-1:0] rand_ad();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return AW'(A0I);
    if (r == 1) return AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    rst_n = 1'b0; AD_R = '0; RVLD = '0;
    idle();
    model_clear();
    #1;
    check_val("reset_a0", a0, 32'h0);
    check_val("reset_rbusy", RBUSY, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write reg5, read it, then reset mid-run
    WE3 = 1'b1; AD3 = 5'd5; WD3 = 32'h1234; tick();
    idle(); set_rd(0, 5'd5); RVLD = 2'b01; tick();
    ISSUE = 1'b1; ISSUE_AD = 5'd5; tick();
    idle(); WE3 = 1'b1; AD3 = 5'd5; WD3 = 32'h9999;
    #1; rst_n = 1'b0; model_clear();
    #1;
    check_val("rst_rd0", RD[DW-1:0], 32'h0);
    check_val("rst_rbusy", RBUSY, 2'b00);
    check_val("rst_stall", STALL, 1'b0);
    check_val("rst_a0", a0, 32'h0);
    tick();
    idle(); rst_n = 1'b1;
    #1;
    check_val("post_rst_rd0", RD[DW-1:0], 32'h0);
    tick();

    // x0 protection
    WE3 = 1'b1; AD3 = 5'd0; WD3 = 32'hDEADBEEF; ISSUE = 1'b1; ISSUE_AD = 5'd0; tick();
    idle(); AD_R = '0; RVLD = 2'b11;
    #1;
    check_val("x0_rd", RD[DW-1:0], 32'h0);
    check_val("x0_rbusy", RBUSY, 2'b00);
    tick();

    // reg10 write and a0 tap
    WE3 = 1'b1; AD3 = 5'd10; WD3 = 32'hCAFE0001; tick();
    idle(); set_rd(1, 5'd10); RVLD = 2'b10;
    #1;
    check_val("a0_after_wr", a0, 32'hCAFE0001);
    check_val("rd1_x10", RD[DW +: DW], 32'hCAFE0001);
    tick();

    // Scoreboard stall across writeback
    AD_R = '0; RVLD = '0; ISSUE = 1'b1; ISSUE_AD = 5'd7; tick();
    idle(); set_rd(0, 5'd7); RVLD = 2'b01;
    #1;
    check_val("stall_pending", STALL, 1'b1);
    tick();
    WE3 = 1'b1; AD3 = 5'd7; WD3 = 32'h55;
    #1;
    check_val("stall_wb", STALL, BYP ? 1'b0 : 1'b1);
    check_val("rd0_wb", RD[DW-1:0], BYP ? 32'h55 : 32'h0);
    tick();
    idle();
    #1;
    check_val("stall_after_wb", STALL, 1'b0);
    check_val("rd0_after_wb", RD[DW-1:0], 32'h55);
    tick();

    // Set-wins collision on reg3
    ISSUE = 1'b1; ISSUE_AD = 5'd3; set_rd(0, 5'd3); tick();
    WE3 = 1'b1; AD3 = 5'd3; WD3 = 32'h33; tick();
    idle();
    #1;
    check_val("collide_rbusy0", RBUSY[0], 1'b1);
    tick();

    // Busy register on an unused port
    ISSUE = 1'b1; ISSUE_AD = 5'd4; tick();
    idle(); set_rd(0, 5'd0); set_rd(1, 5'd4); RVLD = 2'b01;
    #1;
    check_val("unused_rbusy1", RBUSY[1], 1'b1);
    check_val("unused_stall", STALL, 1'b0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      WE3      = ($urandom_range(0, 2) == 0);
      AD3      = rand_ad();
      WD3      = $urandom;
      ISSUE    = ($urandom_range(0, 2) == 0);
      ISSUE_AD = rand_ad();
      for (int k = 0; k < NR; k++) set_rd(k, rand_ad());
      RVLD     = NR'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        model_clear();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
